// File: rtl/alu_issue_sched.sv
// alu_issue_sched: picks the oldest eligible ALU op per channel from the issue
// queue, searching from head with wrap-around. Each channel holds its pick in a
// valid/ready handshake until the ALU accepts it.
//
// Ports:
//   clk, rst (async active-low), ce (clock enable)
//   head          - index of the oldest queue entry
//   allow_issue   - per-channel issue permission
//   could_issue   - entry ready and not yet issued
//   iq_alu        - entry is an ALU op
//   iq_alu0       - entry restricted to channel 0
//   iq_prior_sync - entry blocked by an older outstanding sync
//   flush         - cancels every held issue
//   alu_ready     - per-channel ALU accepts its offered op
//   issue_valid   - channel holds an op
//   issue_idx     - held entry index, channel c at [c*IDXW +: IDXW]
//   issue_oh      - held entry one-hot, channel c at [c*IQ_ENTRIES +: IQ_ENTRIES]
//   held_mask     - OR of all issue_oh
module alu_issue_sched #(
   parameter int unsigned IQ_ENTRIES = 8,
   parameter int unsigned NUM_ALU    = 2,
   parameter int unsigned IDXW       = $clog2(IQ_ENTRIES)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ce,
   input  logic [IDXW-1:0]                 head,
   input  logic [NUM_ALU-1:0]              allow_issue,
   input  logic [IQ_ENTRIES-1:0]           could_issue,
   input  logic [IQ_ENTRIES-1:0]           iq_alu,
   input  logic [IQ_ENTRIES-1:0]           iq_alu0,
   input  logic [IQ_ENTRIES-1:0]           iq_prior_sync,
   input  logic                            flush,
   input  logic [NUM_ALU-1:0]              alu_ready,
   output logic [NUM_ALU-1:0]              issue_valid,
   output logic [NUM_ALU*IDXW-1:0]         issue_idx,
   output logic [NUM_ALU*IQ_ENTRIES-1:0]   issue_oh,
   output logic [IQ_ENTRIES-1:0]           held_mask
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e                             state_q [NUM_ALU];
   state_e                             state_d [NUM_ALU];
   logic [NUM_ALU-1:0][IDXW-1:0]       idx_q, idx_d;
   logic [NUM_ALU-1:0][IQ_ENTRIES-1:0] oh_q, oh_d;
   logic [IQ_ENTRIES-1:0]              held_q, held_d;

   logic [NUM_ALU-1:0]                 accept;
   logic [NUM_ALU-1:0]                 load;
   logic [NUM_ALU-1:0]                 cand_found;
   logic [NUM_ALU-1:0][IDXW-1:0]       cand_idx;
   logic [IQ_ENTRIES-1:0]              released;
   logic [IQ_ENTRIES-1:0]              base_elig;
   logic [IQ_ENTRIES-1:0]              picked;
   logic [IDXW-1:0]                    probe;

   // Handshake completion; entries accepted this cycle become pickable again
   always_comb begin
      accept   = '0;
      released = '0;
      for (int c = 0; c < NUM_ALU; c++) begin
         accept[c] = ce && (state_q[c] == ST_HOLD) && alu_ready[c];
         if (accept[c]) begin
            released = released | oh_q[c];
         end
      end
   end

   assign base_elig = could_issue & iq_alu & ~iq_prior_sync & ~(held_q & ~released);

   // Oldest-first candidate per channel; lower channels claim entries first
   always_comb begin
      picked     = '0;
      cand_found = '0;
      cand_idx   = '0;
      load       = '0;
      probe      = '0;
      for (int c = 0; c < NUM_ALU; c++) begin
         for (int k = 0; k < IQ_ENTRIES; k++) begin
            probe = head + IDXW'(k);
            if (!cand_found[c] && base_elig[probe] && !picked[probe] &&
                ((c == 0) || !iq_alu0[probe])) begin
               cand_found[c] = 1'b1;
               cand_idx[c]   = probe;
            end
         end
         load[c] = ce && allow_issue[c] && cand_found[c] &&
                   ((state_q[c] == ST_IDLE) || accept[c]);
         if (load[c]) begin
            picked[cand_idx[c]] = 1'b1;
         end
      end
   end

   // Channel state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_ALU; c++) begin
            state_q[c] <= ST_IDLE;
         end
         idx_q  <= '0;
         oh_q   <= '0;
         held_q <= '0;
      end else begin
         for (int c = 0; c < NUM_ALU; c++) begin
            state_q[c] <= state_d[c];
         end
         idx_q  <= idx_d;
         oh_q   <= oh_d;
         held_q <= held_d;
      end
   end

   // Next state: flush beats load, load beats plain accept
   always_comb begin
      for (int c = 0; c < NUM_ALU; c++) begin
         state_d[c] = state_q[c];
      end
      idx_d  = idx_q;
      oh_d   = oh_q;
      held_d = '0;
      for (int c = 0; c < NUM_ALU; c++) begin
         if (ce && flush) begin
            state_d[c] = ST_IDLE;
            idx_d[c]   = '0;
            oh_d[c]    = '0;
         end else if (load[c]) begin
            state_d[c] = ST_HOLD;
            idx_d[c]   = cand_idx[c];
            oh_d[c]    = IQ_ENTRIES'(1) << cand_idx[c];
         end else if (accept[c]) begin
            state_d[c] = ST_IDLE;
            idx_d[c]   = '0;
            oh_d[c]    = '0;
         end
         held_d = held_d | oh_d[c];
      end
   end

   // Outputs straight from registered state
   always_comb begin
      issue_valid = '0;
      issue_idx   = '0;
      issue_oh    = '0;
      for (int c = 0; c < NUM_ALU; c++) begin
         issue_valid[c]                         = (state_q[c] == ST_HOLD);
         issue_idx[c*IDXW +: IDXW]              = idx_q[c];
         issue_oh[c*IQ_ENTRIES +: IQ_ENTRIES]   = oh_q[c];
      end
      held_mask = held_q;
   end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched (IQ_ENTRIES=8, NUM_ALU=2).
module tb_alu_issue_sched;

   logic        clk;
   logic        rst;
   logic        ce;
   logic [2:0]  head;
   logic [1:0]  allow_issue;
   logic [7:0]  could_issue;
   logic [7:0]  iq_alu;
   logic [7:0]  iq_alu0;
   logic [7:0]  iq_prior_sync;
   logic        flush;
   logic [1:0]  alu_ready;
   logic [1:0]  issue_valid;
   logic [5:0]  issue_idx;
   logic [15:0] issue_oh;
   logic [7:0]  held_mask;

   int checks;
   int failures;

   alu_issue_sched #(.IQ_ENTRIES(8), .NUM_ALU(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .ce            (ce),
      .head          (head),
      .allow_issue   (allow_issue),
      .could_issue   (could_issue),
      .iq_alu        (iq_alu),
      .iq_alu0       (iq_alu0),
      .iq_prior_sync (iq_prior_sync),
      .flush         (flush),
      .alu_ready     (alu_ready),
      .issue_valid   (issue_valid),
      .issue_idx     (issue_idx),
      .issue_oh      (issue_oh),
      .held_mask     (held_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b0;
      ce            = 1'b1;
      head          = 3'd0;
      allow_issue   = 2'b11;
      could_issue   = 8'h00;
      iq_alu        = 8'hFF;
      iq_alu0       = 8'h00;
      iq_prior_sync = 8'h00;
      flush         = 1'b0;
      alu_ready     = 2'b00;

      // Reset values
      #2;
      check("rst_valid", 32'(issue_valid), 32'h0);
      check("rst_idx",   32'(issue_idx),   32'h0);
      check("rst_oh",    32'(issue_oh),    32'h0);
      check("rst_mask",  32'(held_mask),   32'h0);
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_valid", 32'(issue_valid), 32'h0);

      // Wrap-around priority
      head = 3'd5; could_issue = 8'h21;
      tick();
      check("wrap_valid", 32'(issue_valid), 32'h3);
      check("wrap_idx",   32'(issue_idx),   32'h05);
      check("wrap_oh",    32'(issue_oh),    32'h0120);
      check("wrap_mask",  32'(held_mask),   32'h21);
      could_issue = 8'h00; alu_ready = 2'b11;
      tick();
      check("wrap_drain_valid", 32'(issue_valid), 32'h0);
      check("wrap_drain_mask",  32'(held_mask),   32'h0);
      alu_ready = 2'b00; head = 3'd0;

      // alu0-only op goes to channel 0 only
      could_issue = 8'h04; iq_alu0 = 8'h04;
      tick();
      check("alu0_valid", 32'(issue_valid), 32'h1);
      check("alu0_idx",   32'(issue_idx),   32'h02);
      tick();
      check("alu0_hold_valid", 32'(issue_valid), 32'h1);
      check("alu0_hold_idx",   32'(issue_idx),   32'h02);
      could_issue = 8'h00; alu_ready = 2'b01;
      tick();
      check("alu0_drain_valid", 32'(issue_valid), 32'h0);
      alu_ready = 2'b00; iq_alu0 = 8'h00;

      // Backpressure: held entry never offered to ch1
      could_issue = 8'h08;
      tick();
      check("bp_load_idx", 32'(issue_idx), 32'h03);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_valid", 32'(issue_valid), 32'h1);
         check("bp_hold_idx",   32'(issue_idx),   32'h03);
         check("bp_hold_mask",  32'(held_mask),   32'h08);
      end
      could_issue = 8'h40; alu_ready = 2'b01;
      tick();
      check("bp_b2b_valid", 32'(issue_valid), 32'h1);
      check("bp_b2b_idx",   32'(issue_idx),   32'h06);
      check("bp_b2b_mask",  32'(held_mask),   32'h40);
      could_issue = 8'h00;
      tick();
      check("bp_drain_valid", 32'(issue_valid), 32'h0);
      alu_ready = 2'b00;

      // Sync barrier
      could_issue = 8'h18; iq_prior_sync = 8'h08;
      tick();
      check("sync_valid", 32'(issue_valid), 32'h1);
      check("sync_idx",   32'(issue_idx),   32'h04);
      check("sync_mask",  32'(held_mask),   32'h10);
      could_issue = 8'h00; iq_prior_sync = 8'h00; alu_ready = 2'b01;
      tick();
      alu_ready = 2'b00;

      // Back-to-back issue on channel 0
      could_issue = 8'h01;
      tick();
      check("b2b_first_idx", 32'(issue_idx), 32'h00);
      check("b2b_first_valid", 32'(issue_valid), 32'h1);
      could_issue = 8'h02; alu_ready = 2'b01;
      tick();
      check("b2b_second_valid", 32'(issue_valid), 32'h1);
      check("b2b_second_idx",   32'(issue_idx),   32'h01);
      could_issue = 8'h00;
      tick();
      alu_ready = 2'b00;
      check("b2b_drain_valid", 32'(issue_valid), 32'h0);

      // allow_issue gating: ch0 denied, ch1 takes the entry
      allow_issue = 2'b10; could_issue = 8'h01;
      tick();
      check("allow_valid", 32'(issue_valid), 32'h2);
      check("allow_oh",    32'(issue_oh),    32'h0100);
      could_issue = 8'h00; alu_ready = 2'b10; allow_issue = 2'b11;
      tick();
      alu_ready = 2'b00;

      // Clock enable freezes loads and ignores alu_ready
      ce = 1'b0; could_issue = 8'h01;
      tick();
      check("ce_noload_valid", 32'(issue_valid), 32'h0);
      ce = 1'b1;
      tick();
      check("ce_load_valid", 32'(issue_valid), 32'h1);
      ce = 1'b0; could_issue = 8'h00; alu_ready = 2'b01;
      tick();
      check("ce_noaccept_valid", 32'(issue_valid), 32'h1);
      ce = 1'b1;
      tick();
      check("ce_accept_valid", 32'(issue_valid), 32'h0);
      alu_ready = 2'b00;

      // Flush overrides accept and reload
      could_issue = 8'h03;
      tick();
      check("flush_pre_valid", 32'(issue_valid), 32'h3);
      check("flush_pre_idx",   32'(issue_idx),   32'h08);
      flush = 1'b1; alu_ready = 2'b11; could_issue = 8'h0C;
      tick();
      check("flush_valid", 32'(issue_valid), 32'h0);
      check("flush_mask",  32'(held_mask),   32'h0);
      check("flush_idx",   32'(issue_idx),   32'h0);
      flush = 1'b0; alu_ready = 2'b00; could_issue = 8'h00;
      tick();

      // Asynchronous reset while both channels hold
      could_issue = 8'h03;
      tick();
      check("arst_pre_valid", 32'(issue_valid), 32'h3);
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid", 32'(issue_valid), 32'h0);
      check("arst_mask",  32'(held_mask),   32'h0);
      check("arst_oh",    32'(issue_oh),    32'h0);
      could_issue = 8'h00;
      tick();
      rst = 1'b1;
      tick();
      check("arst_release_valid", 32'(issue_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_sched.md
# alu_issue_sched

Registered, parametrised ALU issue scheduler for the Gambit out-of-order core. Sits between the issue queue and `NUM_ALU` ALU channels. Each cycle it selects the oldest eligible ALU instruction per channel, searching from the queue head with wrap-around. Each selection is held in a per-channel valid/ready handshake until the ALU accepts it.

## Interface
- `IQ_ENTRIES`, 8: issue-queue depth; power of two, ≥ 2.
- `NUM_ALU`, 2: number of ALU channels, 1 to 4; channel 0 is the only one able to execute alu0-only ops.
- `IDXW`, $clog2(IQ_ENTRIES): queue index width.

Ports:
- `clk`  in  1  core clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; when low, all state is frozen.
- `head`  in  IDXW  index of the oldest queue entry.
- `allow_issue`  in  NUM_ALU  per-channel issue permission.
- `could_issue`  in  IQ_ENTRIES  entry operands ready and entry not yet issued.
- `iq_alu`  in  IQ_ENTRIES  entry is an ALU op.
- `iq_alu0`  in  IQ_ENTRIES  entry must execute on ALU 0.
- `iq_prior_sync`  in  IQ_ENTRIES  an older sync is outstanding; entry is ineligible.
- `flush`  in  1  pipeline flush; cancels all held issues.
- `alu_ready`  in  NUM_ALU  channel ALU accepts its offered instruction this cycle.
- `issue_valid`  out  NUM_ALU  channel holds an instruction.
- `issue_idx`  out  NUM_ALU*IDXW  held entry index; channel c occupies bits [c*IDXW +: IDXW].
- `issue_oh`  out  NUM_ALU*IQ_ENTRIES  one-hot of the held entry, per channel.
- `held_mask`  out  IQ_ENTRIES  OR of all `issue_oh`; the queue uses it to suppress `could_issue`.

## Operation
- Eligibility of entry n for channel c requires all of the following:
  - `could_issue[n] & iq_alu[n] & !iq_prior_sync[n]`.
  - n is not in `held_mask`, unless it is being accepted this cycle.
  - n is not picked by a lower-numbered channel this cycle.
  - `c==0 | !iq_alu0[n]`.
- Search order: `head`, `head+1`, … modulo IQ_ENTRIES. The first eligible entry is the candidate.
- Channels are resolved in ascending order. Channel 0 has priority over all others.
- Each channel has two states, IDLE and HOLD.
- IDLE:
  - If `ce & allow_issue[c] & candidate`, load the candidate and move to HOLD.
  - Otherwise stay in IDLE.
- HOLD:
  - `issue_valid[c]=1`; idx and oh are stable.
  - Acceptance is `alu_ready[c] & ce`.
  - On acceptance with a new candidate and `allow_issue[c]`, load the new candidate and stay in HOLD (back-to-back issue).
  - On acceptance with no new candidate, move to IDLE.
  - Without acceptance, hold indefinitely. Changes to `could_issue` or `allow_issue` do not cancel the hold.
- `flush` (sampled when `ce`) moves all channels to IDLE and clears outputs, overriding loads and accepts in the same cycle.
- When `NUM_ALU==1`, all `iq_alu0` entries are legal on channel 0 and no other channel logic exists.
- All-zero `could_issue` produces no loads. A candidate search that wraps past IQ_ENTRIES-1 continues at 0 and stops at `head-1`.

## Timing
- Reset (rst=0, asynchronous): all channels IDLE; `issue_valid`, `issue_idx`, `issue_oh` and `held_mask` are all 0.
- Selection is combinational. A candidate present in cycle t appears on `issue_valid`/`issue_idx` in cycle t+1, so latency is 1.
- Handshake completes on the edge where `issue_valid & alu_ready`. A back-to-back load becomes visible in the cycle after that edge, so sustained throughput is 1 per channel per cycle.
- `held_mask` is registered and changes only on the same edges as the channel state.
- `ce=0`: no state change, and `alu_ready` is ignored.
- Rst deassertion mid-stream: the first load can occur on the first `ce` edge after release.

## Test plan
- Reset: drive rst=0 while channels are in HOLD → all outputs 0 immediately, asynchronously; after release with `could_issue=0`, outputs remain 0.
- Wrap-around priority: `head=5`, `could_issue=8'h21` (entries 0 and 5), all ALU ops, both allows on → next cycle ch0 idx=5, ch1 idx=0, `held_mask=8'h21`.
- alu0-only: `could_issue=8'h04` with `iq_alu0[2]=1` → ch0 idx=2, `issue_valid=2'b01`; repeat with ch0 in HOLD and not ready → ch1 stays IDLE.
- Backpressure: ch0 holds idx=3 with `alu_ready[0]=0` for 3 cycles, `could_issue[3]` still 1 → idx stays 3, entry 3 is never offered to ch1; `alu_ready[0]=1` with entry 6 eligible → next cycle ch0 idx=6.
- Sync barrier: `head=0`, `could_issue=8'h18`, `iq_prior_sync[3]=1` → ch0 idx=4, ch1 IDLE.
- Flush: both channels in HOLD, `flush=1` together with `alu_ready=2'b11` and new candidates → next cycle `issue_valid=0`, `held_mask=0`.
